// File: rtl/reg_arbiter.sv
// Two-port round-robin arbiter in front of a simple register file.
// Each granted access runs IDLE -> ACCESS -> RESP: the strobe goes out in
// ACCESS and the requester's ack comes back in RESP.
module reg_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_write,
    input  logic [DATA_W-1:0] data_read,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              gnt_q, gnt_d;     // id of the access in flight
    logic              last_q, last_d;   // id granted most recently
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic              m0_ack_q, m0_ack_d;
    logic              m1_ack_q, m1_ack_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_write_q, data_write_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
    logic              pick;

    // Arbitration and next-state / next-output logic for the access sequencer.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_d       = last_q;
        read_d       = 1'b0;
        write_d      = 1'b0;
        m0_ack_d     = 1'b0;
        m1_ack_d     = 1'b0;
        addr_d       = addr_q;
        data_write_d = data_write_q;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        // On contention the port not granted last time wins.
        pick         = (m0_req && m1_req) ? ~last_q : m1_req;

        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    gnt_d        = pick;
                    addr_d       = pick ? m1_addr : m0_addr;
                    data_write_d = pick ? m1_wdata : m0_wdata;
                    write_d      = pick ? m1_we : m0_we;
                    read_d       = pick ? ~m1_we : ~m0_we;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                if (read_q) begin
                    if (gnt_q) m1_rdata_d = data_read;
                    else       m0_rdata_d = data_read;
                end
                m0_ack_d = ~gnt_q;
                m1_ack_d = gnt_q;
                state_d  = RESP;
            end
            RESP: begin
                last_d  = gnt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            gnt_q        <= 1'b0;
            last_q       <= 1'b1;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
            addr_q       <= '0;
            data_write_q <= '0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_q       <= last_d;
            read_q       <= read_d;
            write_q      <= write_d;
            m0_ack_q     <= m0_ack_d;
            m1_ack_q     <= m1_ack_d;
            addr_q       <= addr_d;
            data_write_q <= data_write_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    assign read       = read_q;
    assign write      = write_q;
    assign m0_ack     = m0_ack_q;
    assign m1_ack     = m1_ack_q;
    assign addr       = addr_q;
    assign data_write = data_write_q;
    assign m0_rdata   = m0_rdata_q;
    assign m1_rdata   = m1_rdata_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: doc/reg_arbiter.md
REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001 The block SHALL expose parameters ADDR_W, default 6, register address width; DATA_W, default 8, register data width.
REQ-002 The block SHALL have port clk  input  1  peripheral clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have ports m0_req, m1_req  input  1  requester N asks for one register access; held high until mN_ack is seen.
REQ-005 The block SHALL have ports m0_we, m1_we  input  1  1 = write, 0 = read; valid while mN_req is high.
REQ-006 The block SHALL have ports m0_addr, m1_addr  input  ADDR_W  target register address.
REQ-007 The block SHALL have ports m0_wdata, m1_wdata  input  DATA_W  write data.
REQ-008 The block SHALL have ports m0_ack, m1_ack  output  1  one-cycle access-complete pulse.
REQ-009 The block SHALL have ports m0_rdata, m1_rdata  output  DATA_W  read result, valid from the ack cycle until the next read completion for that port.
REQ-010 The block SHALL have ports read, write  output  1  one-cycle strobes to the register file.
REQ-011 The block SHALL have port addr  output  ADDR_W  register file address.
REQ-012 The block SHALL have port data_write  output  DATA_W  register file write data.
REQ-013 The block SHALL have port data_read  input  DATA_W  register file read data, combinational from addr (same cycle).
REQ-014 The block SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-016 IDLE with at least one mN_req high SHALL latch the winner's id, we, addr and wdata and go to ACCESS; with no request it SHALL stay in IDLE.
REQ-017 Arbitration SHALL be round-robin: a single requester wins; with both requesting, the requester not granted most recently wins.
REQ-018 ACCESS SHALL drive addr/data_write from the latched fields and assert exactly one of write (we=1) or read (we=0) for exactly one cycle, then go to RESP.
REQ-019 On a read, the edge ending ACCESS SHALL load data_read into the winner's mN_rdata; the other port's rdata SHALL be unchanged; writes SHALL leave both rdata unchanged.
REQ-020 RESP SHALL assert the winner's mN_ack for exactly one cycle, update the last-grant pointer, and go to IDLE.
REQ-021 Latency SHALL be: request sampled in IDLE at cycle T, strobe at T+1, ack at T+2, next arbitration no earlier than T+3.
REQ-022 Requester inputs SHALL be ignored outside IDLE; changes to req, we, addr or wdata after the latch SHALL NOT affect the access in flight.
REQ-023 A req still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-024 read and write SHALL never be high together; at most one mN_ack SHALL be high per cycle.
REQ-025 addr and data_write SHALL hold their last values outside ACCESS; they SHALL be meaningful only while a strobe is high.

Reset
REQ-026 rst high at a clock edge SHALL force IDLE, with read, write, m0_ack, m1_ack and busy all 0, addr 0, data_write 0, m0_rdata and m1_rdata 0, and the last-grant pointer set to m1 so that m0 wins the first contention.
REQ-027 Reset asserted in ACCESS or RESP SHALL abort the access: no ack SHALL be issued for it, and any strobe SHALL drop on the reset edge.
REQ-028 The first arbitration after reset release SHALL occur on the first edge with rst low.

Verification
REQ-029 Test: after reset, m0 write we=1 addr=0x05 wdata=0xA5 -> write=1 addr=0x05 data_write=0xA5 at T+1, m0_ack at T+2, m1_ack stays 0.
REQ-030 Test: m1 read addr=0x05 with data_read model returning 0xA5 -> read=1 at T+1; m1_ack=1 and m1_rdata=0xA5 at T+2; m0_rdata unchanged.
REQ-031 Test: m0 and m1 request in the same cycle, both holding req and re-requesting after each ack -> grants alternate m0, m1, m0, m1; each ack is 3 cycles apart.
REQ-032 Test: m0 changes addr from 0x01 to 0x3F during ACCESS -> the strobe uses addr 0x01.
REQ-033 Test: rst asserted during ACCESS of an m1 read -> the next cycle shows IDLE, no m1_ack, all outputs 0, and m0 wins the next contention.
REQ-034 Test: random request traffic for 10k cycles -> never read&write together, never two acks in one cycle, no starvation (each waiting requester is served within 6 cycles).
